// File: rtl/tx_arbiter.sv
// Two-VC to four-destination transmit arbiter. VC0 has priority, VC1 gets a turn
// after four consecutive VC0 wins. Each destination has its own word counter.
module tx_arbiter #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc0_empty,
  output logic              vc0_pop,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              vc1_empty,
  output logic              vc1_pop,
  input  logic [3:0]        dest_almost_full,
  output logic [3:0]        dest_push,
  output logic [DATA_W-1:0] dest_data,
  output logic              idle,
  input  logic [1:0]        count_sel,
  output logic [7:0]        count_out
);
  localparam logic [2:0] STREAK_MAX = 3'd4;

  function automatic logic [2:0] streak_sat_inc(input logic [2:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 3'd1;
  endfunction

  function automatic logic [3:0] dest_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  logic [1:0]        vc0_dest_p0;
  logic [1:0]        vc1_dest_p0;
  logic              elig0_p0;
  logic              elig1_p0;
  logic              grant0_p0;
  logic              grant1_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [1:0]        dest_p0;
  logic [2:0]        streak;
  logic [3:0]        push_p1;
  logic [DATA_W-1:0] data_p1;
  logic              idle_p1;
  logic [7:0]        cnt [4];

  // Stage p0: eligibility and same-cycle grant; a blocked head only stalls its own VC
  always_comb begin
    vc0_dest_p0 = vc0_data[DATA_W-1 -: 2];
    vc1_dest_p0 = vc1_data[DATA_W-1 -: 2];
    elig0_p0    = !vc0_empty && !dest_almost_full[vc0_dest_p0];
    elig1_p0    = !vc1_empty && !dest_almost_full[vc1_dest_p0];
    grant1_p0   = elig1_p0 && ((streak == STREAK_MAX) || !elig0_p0) && !reset;
    grant0_p0   = elig0_p0 && !(elig1_p0 && (streak == STREAK_MAX)) && !reset;
    vld_p0      = grant0_p0 || grant1_p0;
    data_p0     = grant1_p0 ? vc1_data : vc0_data;
    dest_p0     = grant1_p0 ? vc1_dest_p0 : vc0_dest_p0;
  end

  assign vc0_pop = grant0_p0;
  assign vc1_pop = grant1_p0;

  // Stage p1: registered push/data toward destinations, streak, idle and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak  <= '0;
      push_p1 <= '0;
      data_p1 <= '0;
      idle_p1 <= 1'b1;
      for (int d = 0; d < 4; d++) cnt[d] <= '0;
    end else begin
      if (grant0_p0)      streak <= streak_sat_inc(streak);
      else if (grant1_p0) streak <= '0;
      push_p1 <= vld_p0 ? dest_onehot(dest_p0) : 4'b0000;
      if (vld_p0) data_p1 <= data_p0;
      idle_p1 <= vc0_empty && vc1_empty && !vld_p0;
      for (int d = 0; d < 4; d++) begin
        if (push_p1[d]) cnt[d] <= cnt[d] + 8'd1;
      end
    end
  end

  assign dest_push = push_p1;
  assign dest_data = data_p1;
  assign idle      = idle_p1;
  assign count_out = cnt[count_sel];

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: queue-based upstream FIFO model, per-cycle
// expected outputs pushed by the driver and consumed by an independent monitor.
module tb_tx_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] vc0_data, vc1_data, dest_data;
  logic       vc0_empty, vc1_empty, vc0_pop, vc1_pop, idle;
  logic [3:0] dest_almost_full, dest_push;
  logic [1:0] count_sel;
  logic [7:0] count_out;

  always #5 clk = ~clk;

  tx_arbiter #(.DATA_W(10)) dut (
    .clk(clk), .reset(reset),
    .vc0_data(vc0_data), .vc0_empty(vc0_empty), .vc0_pop(vc0_pop),
    .vc1_data(vc1_data), .vc1_empty(vc1_empty), .vc1_pop(vc1_pop),
    .dest_almost_full(dest_almost_full), .dest_push(dest_push),
    .dest_data(dest_data), .idle(idle),
    .count_sel(count_sel), .count_out(count_out)
  );

  typedef struct packed {
    logic       v;
    logic [9:0] w;
    logic       idl;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  exp_t       exp_q[$];
  logic [1:0] pop_log[$];
  logic [7:0] exp_cnt [4];
  logic [9:0] last_data_m;
  int         vc0_run;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int d = 0; d < 4; d++) exp_cnt[d] = 8'd0;
    last_data_m = 10'd0;
    vc0_run = 0;
  endtask

  // One arbitration cycle: drive heads, predict the grant from the rules, log expectations
  task automatic step(input logic [3:0] af, input logic [1:0] sel);
    logic       e0, e1, el0, el1, g0, g1;
    logic [9:0] h0, h1, w;
    exp_t       ne;
    @(negedge clk);
    dest_almost_full = af;
    count_sel = sel;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    h0 = e0 ? 10'($urandom) : q0[0];
    h1 = e1 ? 10'($urandom) : q1[0];
    vc0_empty = e0;
    vc1_empty = e1;
    vc0_data  = h0;
    vc1_data  = h1;
    #1;
    el0 = !e0 && !af[h0[9:8]];
    el1 = !e1 && !af[h1[9:8]];
    g1  = el1 && (vc0_run >= 4 || !el0);
    g0  = el0 && !g1;
    chk("vc0_pop", 32'(vc0_pop), 32'(g0));
    chk("vc1_pop", 32'(vc1_pop), 32'(g1));
    pop_log.push_back({vc1_pop, vc0_pop});
    w = 10'd0;
    if (g0) begin
      w = q0.pop_front();
      vc0_run = (vc0_run < 4) ? vc0_run + 1 : 4;
    end else if (g1) begin
      w = q1.pop_front();
      vc0_run = 0;
    end
    ne.v   = g0 || g1;
    ne.w   = w;
    ne.idl = e0 && e1 && !g0 && !g1;
    exp_q.push_back(ne);
    mon_en = 1'b1;
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 600) begin
      step(4'b0000, (sel < 0) ? 2'($urandom) : 2'(sel));
      n++;
    end
    chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
    step(4'b0000, (sel < 0) ? 2'($urandom) : 2'(sel));
    step(4'b0000, (sel < 0) ? 2'($urandom) : 2'(sel));
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 60 && q0.size() < 8) q0.push_back(10'($urandom));
      if ($urandom_range(0, 99) < 50 && q1.size() < 8) q1.push_back(10'($urandom));
      step(4'($urandom) & 4'($urandom), 2'($urandom));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_vc0_pop"}, 32'(vc0_pop), 32'd0);
    chk({tag, "_vc1_pop"}, 32'(vc1_pop), 32'd0);
    chk({tag, "_dest_push"}, 32'(dest_push), 32'd0);
    chk({tag, "_dest_data"}, 32'(dest_data), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd1);
    for (int s = 0; s < 4; s++) begin
      count_sel = 2'(s);
      #1;
      chk({tag, "_count_out"}, 32'(count_out), 32'd0);
    end
  endtask

  // Monitor: one expectation per enabled clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (mon_en) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("exp_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("idle", 32'(idle), 32'(e.idl));
          chk("count_out", 32'(count_out), 32'(exp_cnt[count_sel]));
          if (e.v) begin
            chk("dest_push", 32'(dest_push), 32'(4'b0001 << e.w[9:8]));
            chk("dest_data", 32'(dest_data), 32'(e.w));
            last_data_m = e.w;
            exp_cnt[e.w[9:8]] = exp_cnt[e.w[9:8]] + 8'd1;
          end else begin
            chk("dest_push_none", 32'(dest_push), 32'd0);
            chk("dest_data_hold", 32'(dest_data), 32'(last_data_m));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    vc0_empty = 1'b0;
    vc0_data  = 10'h155;
    vc1_empty = 1'b0;
    vc1_data  = 10'h2AA;
    dest_almost_full = 4'b0000;
    count_sel = 2'd0;

    // Reset held with both VCs requesting
    @(negedge clk);
    #1;
    check_reset_state("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Fairness: both VCs to destination 0, first grant in first cycle after release
    for (int i = 0; i < 12; i++) begin
      q0.push_back({2'b00, 8'($urandom)});
      q1.push_back({2'b00, 8'($urandom)});
    end
    pop_log.delete();
    for (int i = 0; i < 10; i++) step(4'b0000, 2'd0);
    for (int i = 0; i < 10; i++)
      chk("fair_pattern", 32'(pop_log[i]), (i % 5 == 4) ? 32'd2 : 32'd1);
    drain(-1);

    // Single route to destination 2
    q0.push_back(10'h2A5);
    step(4'b0000, 2'd2);
    step(4'b0000, 2'd2);
    @(posedge clk);
    #2;
    chk("single_count2", 32'(count_out), 32'd1);

    // Backpressure on destination 0 must not stall VC1 headed to destination 3
    q0.push_back({2'b00, 8'h11});
    q1.push_back({2'b11, 8'h22});
    pop_log.delete();
    step(4'b0001, 2'd3);
    chk("bp_pops", 32'(pop_log[0]), 32'd2);
    @(posedge clk);
    #2;
    chk("bp_push", 32'(dest_push), 32'h8);
    drain(-1);

    // Counter wrap on destination 1
    for (int i = 0; i < 256; i++) q0.push_back({2'b01, 8'(i)});
    drain(1);
    @(posedge clk);
    #2;
    chk("wrap_count1", 32'(count_out), 32'd0);

    random_phase(500);
    drain(-1);

    // Reset pulsed while a word is being pushed to destination 1
    for (int i = 0; i < 6; i++) q0.push_back({2'b01, 8'($urandom)});
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 2'd1);
      @(posedge clk);
      #2;
      if (dest_push == 4'b0010) break;
    end
    chk("mid_push_seen", 32'(dest_push), 32'h2);
    mon_en = 1'b0;
    reset = 1'b1;
    vc0_empty = 1'b0;
    vc1_empty = 1'b0;
    dest_almost_full = 4'b0000;
    #1;
    check_reset_state("midrst");
    clear_model();
    @(negedge clk);
    chk("midrst_hold_vc0_pop", 32'(vc0_pop), 32'd0);
    chk("midrst_hold_vc1_pop", 32'(vc1_pop), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    drain(-1);

    random_phase(200);
    drain(-1);
    @(posedge clk);
    #2;
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose `vc0_data`, input, 10 bits: head word of upstream VC0 FIFO, valid whenever `vc0_empty`=0 (show-ahead).
REQ-004 The block SHALL expose `vc0_empty`, input, 1 bit: VC0 FIFO empty flag.
REQ-005 The block SHALL expose `vc0_pop`, output, 1 bit: pop strobe to VC0 FIFO.
REQ-006 The block SHALL expose `vc1_data`, input, 10 bits: head word of VC1 FIFO, same rules as VC0.
REQ-007 The block SHALL expose `vc1_empty`, input, 1 bit: VC1 FIFO empty flag.
REQ-008 The block SHALL expose `vc1_pop`, output, 1 bit: pop strobe to VC1 FIFO.
REQ-009 The block SHALL expose `dest_almost_full`, input, 4 bits: almost_full flags of the four downstream destination FIFOs, bit d = destination d.
REQ-010 The block SHALL expose `dest_push`, output, 4 bits: one-hot push strobes to the destination FIFOs.
REQ-011 The block SHALL expose `dest_data`, output, 10 bits: data bus shared by all destination FIFOs.
REQ-012 The block SHALL expose `idle`, output, 1 bit: high when no traffic is pending or in flight.
REQ-013 The block SHALL expose `count_sel`, input, 2 bits: selects which destination counter is shown.
REQ-014 The block SHALL expose `count_out`, output, 8 bits: word count of the destination selected by `count_sel`.

Function
REQ-015 Destination of a word SHALL be its bits [9:8]; the full 10-bit word is forwarded unchanged.
REQ-016 eligibleN SHALL be 1 only when vcN_empty=0 and dest_almost_full[vcN_data[9:8]]=0.
REQ-017 Grant (combinational, same cycle) SHALL be: if streak=4 and eligible1, grant VC1; else if eligible0, grant VC0; else if eligible1, grant VC1; else no grant.
REQ-018 vcN_pop SHALL equal grantN; at most one pop SHALL be high per cycle.
REQ-019 The 3-bit streak counter SHALL do the following per cycle: VC0 grant -> increment, saturating at 4; VC1 grant -> 0; no grant -> unchanged.
REQ-020 Latency SHALL be 1 cycle: the edge that ends a grant cycle registers dest_data = granted word and dest_push = one-hot(word[9:8]).
REQ-021 In a cycle with no grant, the next dest_push SHALL be 4'b0000 and dest_data SHALL hold its last value.
REQ-022 A blocked VC (head destination almost full) SHALL NOT stall the other VC; head-of-line blocking SHALL be per VC only.
REQ-023 Four 8-bit counters cnt[0..3] SHALL be kept; cnt[d] increments on each clock edge where registered dest_push[d]=1, wrapping 255 -> 0.
REQ-024 count_out SHALL equal cnt[count_sel], combinationally.
REQ-025 idle SHALL be registered as vc0_empty & vc1_empty & no grant in the current cycle.
REQ-026 A simultaneous VC0 and VC1 request to the same destination SHALL resolve per REQ-017; the loser stays at its FIFO head, not popped.

Reset
REQ-027 While reset=1, vc0_pop and vc1_pop SHALL be forced to 0 regardless of inputs.
REQ-028 Reset assertion SHALL immediately (asynchronously) set dest_push=0, dest_data=0, streak=0, all cnt=0, and idle=1.
REQ-029 Reset asserted mid-transfer SHALL discard any registered word; no push SHALL occur after release until a new grant.
REQ-030 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-031 Single route: VC0 holds 10'h2A5, VC1 empty, no almost_full -> vc0_pop=1 that cycle; next cycle dest_push=4'b0100, dest_data=10'h2A5; count_sel=2 then gives count_out=1.
REQ-032 Fairness: both VCs continuously non-empty, all to destination 0 -> grant pattern VC0,VC0,VC0,VC0,VC1 repeating.
REQ-033 Backpressure: dest_almost_full=4'b0001, VC0 head to destination 0, VC1 head to destination 3 -> vc0_pop=0, vc1_pop=1, dest_push=4'b1000 next cycle.
REQ-034 Counter wrap: 256 words pushed to destination 1 -> count_out (count_sel=1) returns to 0.
REQ-035 Reset mid-operation: reset pulsed while dest_push=4'b0010 -> dest_push=0, counters=0, idle=1 immediately; pops stay low until reset deasserts.
